// File: rtl/stage_ex_muldiv.sv
// stage_ex_muldiv: RV32I/RV64I execute stage with an iterative M unit and a single-entry registered output buffer
module stage_ex_muldiv #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OP_IMM = 7'b0010011, OP = 7'b0110011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [SW-1:0] cnt;
    logic [2:0] f3_r;
    logic na_r, nb_r, bz_r, wreg_r;
    logic [4:0] wd_r;
    logic [XLEN-1:0] ma_r, mb_r;
    logic [2*XLEN-1:0] p_r, p_step, prod;
    logic buf_free, accept, is_m_enc, is_m, sub, sa, sb, na, nb, ge;
    logic [SW-1:0] sh;
    logic [XLEN-1:0] alu, alu_res, ma, mb, q, r, quo, rem, md_res;
    logic [XLEN:0] mul_sum, sh_v, diff;

    assign buf_free = !out_valid || out_ready;
    assign in_ready = rdy && state == IDLE && buf_free;
    assign accept   = in_valid && in_ready;
    assign is_m_enc = opcode_i == OP && funct7_i == 7'b0000001;
    assign is_m     = MULDIV_EN && is_m_enc;
    assign busy     = state != IDLE;

    always_comb begin
        sh  = reg2_i[SW-1:0];
        sub = opcode_i == OP && funct7_i[5];
        case (funct3_i)
            3'd0:    alu = sub ? reg1_i - reg2_i : reg1_i + reg2_i;
            3'd1:    alu = reg1_i << sh;
            3'd2:    alu = XLEN'($signed(reg1_i) < $signed(reg2_i));
            3'd3:    alu = XLEN'(reg1_i < reg2_i);
            3'd4:    alu = reg1_i ^ reg2_i;
            3'd5:    alu = funct7_i[5] ? $unsigned($signed(reg1_i) >>> sh) : reg1_i >> sh;
            3'd6:    alu = reg1_i | reg2_i;
            default: alu = reg1_i & reg2_i;
        endcase
        alu_res = is_m_enc ? '0 :
                  (opcode_i == OP_IMM || opcode_i == OP) ? alu :
                  (opcode_i == LUI || opcode_i == AUIPC || opcode_i == JAL || opcode_i == JALR) ? reg1_i : '0;
    end

    // M ops run on operand magnitudes; the sign is restored when the result is written
    always_comb begin
        sa = funct3_i inside {3'd1, 3'd2, 3'd4, 3'd6};
        sb = funct3_i inside {3'd1, 3'd4, 3'd6};
        na = sa && reg1_i[XLEN-1];
        nb = sb && reg2_i[XLEN-1];
        ma = na ? -reg1_i : reg1_i;
        mb = nb ? -reg2_i : reg2_i;
        mul_sum = {1'b0, p_r[2*XLEN-1:XLEN]} + (p_r[0] ? {1'b0, ma_r} : '0);
        sh_v = {p_r[2*XLEN-1:XLEN], p_r[XLEN-1]};
        diff = sh_v - {1'b0, mb_r};
        ge = !diff[XLEN];
        p_step = f3_r[2] ? {ge ? diff[XLEN-1:0] : sh_v[XLEN-1:0], p_r[XLEN-2:0], ge}
                         : {mul_sum, p_r[XLEN-1:1]};
        prod = (na_r ^ nb_r) ? -p_r : p_r;
        q = p_r[XLEN-1:0];
        r = p_r[2*XLEN-1:XLEN];
        quo = bz_r ? '1 : (na_r ^ nb_r) ? -q : q;
        rem = na_r ? -r : r;
        md_res = f3_r[2] ? (f3_r[1] ? rem : quo) : (f3_r == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (accept && is_m ? CALC : IDLE) :
                  state == CALC ? (cnt == SW'(XLEN-1) ? DONE : CALC) :
                  (buf_free ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            wd_o      <= '0;
            wreg_o    <= 1'b0;
            wdata_o   <= '0;
        end else if (rdy) begin
            state <= state_n;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && !is_m) begin
                out_valid <= 1'b1;
                wd_o      <= wd_i;
                wreg_o    <= wreg_i;
                wdata_o   <= alu_res;
            end
            if (state == DONE && buf_free) begin
                out_valid <= 1'b1;
                wd_o      <= wd_r;
                wreg_o    <= wreg_r;
                wdata_o   <= md_res;
            end
            if (accept && is_m) begin
                cnt    <= '0;
                f3_r   <= funct3_i;
                na_r   <= na;
                nb_r   <= nb;
                bz_r   <= reg2_i == '0;
                ma_r   <= ma;
                mb_r   <= mb;
                wd_r   <= wd_i;
                wreg_r <= wreg_i;
                p_r    <= {{XLEN{1'b0}}, funct3_i[2] ? ma : mb};
            end
            if (state == CALC) begin
                p_r <= p_step;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stage_ex_muldiv.sv
// tb_stage_ex_muldiv: scoreboard bench for the execute stage (XLEN=32, M unit enabled)
module tb_stage_ex_muldiv;
    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, in_valid = 1'b0, out_ready = 1'b1, wreg = 1'b1;
    logic in_ready, out_valid, wreg_o, busy;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic [31:0] reg1 = '0, reg2 = '0, wdata_o;
    logic [4:0] wd = '0, wd_o;
    logic [37:0] exp_q[$];
    int checks = 0, errors = 0;

    localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, LUI = 7'h37, JAL = 7'h6F, LOAD = 7'h03;
    localparam logic [6:0] F0 = 7'h00, FS = 7'h20, FM = 7'h01;

    stage_ex_muldiv #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7), .reg1_i(reg1), .reg2_i(reg2),
        .wd_i(wd), .wreg_i(wreg), .out_valid(out_valid), .out_ready(out_ready),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && rdy && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output wd=%0d wdata=%h", wd_o, wdata_o);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if ({wd_o, wreg_o, wdata_o} !== e) begin
                    errors++;
                    $display("FAIL result wd=%0d wreg=%b wdata=%h expected wd=%0d wreg=%b wdata=%h",
                             wd_o, wreg_o, wdata_o, e[37:33], e[32], e[31:0]);
                end
            end
        end
    end

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        in_valid = 1'b1; opcode = op; funct3 = f3; funct7 = f7; reg1 = a; reg2 = b; wd = d;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] e, input bit push);
        int t = 0;
        set_in(op, f3, f7, a, b, d);
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end else if (push)
            exp_q.push_back({d, 1'b1, e});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 200);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, wreg_o, busy, wd_o, wdata_o} !== 40'd0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b wreg=%b busy=%b wd=%0d wdata=%h required all 0",
                     out_valid, wreg_o, busy, wd_o, wdata_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_alu();
        int n;
        send(OPI, 3'd0, F0, 32'h7FFF_FFFF, 32'h1, 5'd1, 32'h8000_0000, 1);
        #1;
        checks++;
        if (out_valid !== 1'b1 || wdata_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL addi_latency out_valid=%b wdata=%h required 1 80000000", out_valid, wdata_o);
        end
        send(OPR, 3'd5, FS, 32'h8000_0000, 32'h24, 5'd2, 32'hF800_0000, 1);
        send(OPR, 3'd2, F0, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h1, 1);
        send(OPR, 3'd3, F0, 32'hFFFF_FFFF, 32'h1, 5'd4, 32'h0, 1);
        send(OPR, 3'd0, FS, 32'h5, 32'h7, 5'd5, 32'hFFFF_FFFE, 1);
        send(OPI, 3'd0, 7'h60, 32'h1000, 32'hFFFF_FC00, 5'd6, 32'h0000_0C00, 1);
        send(OPI, 3'd5, F0, 32'h8000_0000, 32'h4, 5'd7, 32'h0800_0000, 1);
        send(OPI, 3'd5, FS, 32'h8000_0000, 32'h404, 5'd8, 32'hF800_0000, 1);
        send(OPR, 3'd1, F0, 32'h1, 32'h3F, 5'd9, 32'h8000_0000, 1);
        send(OPR, 3'd4, F0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd10, 32'hAAAA_AAAA, 1);
        send(OPR, 3'd6, F0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd11, 32'hAFAF_AFAF, 1);
        send(OPR, 3'd7, F0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd12, 32'h0505_0505, 1);
        send(OPI, 3'd3, F0, 32'h0, 32'h1, 5'd13, 32'h1, 1);
        send(LUI, 3'd0, F0, 32'h1234_5000, 32'h0, 5'd14, 32'h1234_5000, 1);
        send(JAL, 3'd0, F0, 32'h0000_0104, 32'h0, 5'd15, 32'h0000_0104, 1);
        send(LOAD, 3'd2, F0, 32'hDEAD_BEEF, 32'h4, 5'd16, 32'h0, 1);
        wait_out(n);
    endtask

    task automatic test_mul();
        int n;
        logic bad;
        repeat (2) @(posedge clk);
        #1;
        send(OPR, 3'd1, FM, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000, 1);
        n = 0;
        bad = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!out_valid && (busy !== 1'b1 || in_ready !== 1'b0)) bad = 1'b1;
        end while (!out_valid && n < 200);
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL mulh_latency got %0d edges required 33", n);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mulh_busy busy/in_ready wrong during calc, required busy=1 in_ready=0");
        end
        send(OPR, 3'd0, FM, 32'h3, 32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFA, 1);
        send(OPR, 3'd3, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE, 1);
        send(OPR, 3'd2, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFF, 1);
        send(OPR, 3'd1, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'h0, 1);
        wait_out(n);
    endtask

    task automatic test_div();
        int n;
        send(OPR, 3'd4, FM, 32'h7, 32'h0, 5'd22, 32'hFFFF_FFFF, 1);
        send(OPR, 3'd6, FM, 32'h7, 32'h0, 5'd23, 32'h7, 1);
        send(OPR, 3'd4, FM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1);
        send(OPR, 3'd6, FM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'h0, 1);
        send(OPR, 3'd7, FM, 32'h10, 32'h3, 5'd26, 32'h1, 1);
        send(OPR, 3'd6, FM, 32'hFFFF_FFF9, 32'h2, 5'd27, 32'hFFFF_FFFF, 1);
        send(OPR, 3'd4, FM, 32'hFFFF_FFF9, 32'h2, 5'd28, 32'hFFFF_FFFD, 1);
        send(OPR, 3'd5, FM, 32'hFFFF_FFFF, 32'h2, 5'd29, 32'h7FFF_FFFF, 1);
        wait_out(n);
    endtask

    task automatic test_back_to_back();
        int n;
        logic held;
        repeat (2) @(posedge clk);
        #1;
        send(OPR, 3'd0, F0, 32'd10, 32'd20, 5'd30, 32'd30, 1);
        send(OPR, 3'd0, F0, 32'd1, 32'd2, 5'd31, 32'd3, 1);
        checks++;
        if (out_valid !== 1'b1 || wdata_o !== 32'd3) begin
            errors++;
            $display("FAIL back_to_back out_valid=%b wdata=%h required 1 00000003", out_valid, wdata_o);
        end
        wait_out(n);
    endtask

    task automatic test_backpressure();
        int n;
        logic held;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(OPR, 3'd0, F0, 32'h100, 32'h23, 5'd1, 32'h123, 1);
        set_in(OPR, 3'd0, F0, 32'h200, 32'h34, 5'd2);
        held = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || wdata_o !== 32'h123 || wd_o !== 5'd1) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL backpressure_hold wdata=%h in_ready=%b required 00000123 0", wdata_o, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release in_ready=%b required 1", in_ready);
        end
        exp_q.push_back({5'd2, 1'b1, 32'h234});
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || wdata_o !== 32'h234) begin
            errors++;
            $display("FAIL backpressure_next out_valid=%b wdata=%h required 1 00000234", out_valid, wdata_o);
        end
        wait_out(n);
    endtask

    task automatic test_rdy_stall();
        int n;
        logic frozen;
        repeat (2) @(posedge clk);
        #1;
        send(OPR, 3'd4, FM, 32'd100, 32'd7, 5'd3, 32'd14, 1);
        n = 0;
        frozen = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 10) rdy = 1'b0;
            if (n == 12 && (in_ready !== 1'b0 || out_valid !== 1'b0)) frozen = 1'b0;
            if (n == 15) rdy = 1'b1;
        end while (!out_valid && n < 200);
        checks++;
        if (n != 38) begin
            errors++;
            $display("FAIL rdy_stall_latency got %0d edges required 38", n);
        end
        checks++;
        if (!frozen) begin
            errors++;
            $display("FAIL rdy_stall_in_ready in_ready nonzero while rdy=0, required 0");
        end
        wait_out(n);
    endtask

    task automatic test_rst_abort();
        int n;
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        send(OPR, 3'd0, FM, 32'd5, 32'd6, 5'd4, 32'd30, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort out_valid=%b busy=%b in_ready=%b required 0 0 1", out_valid, busy, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_abort_result out_valid rose after abort, required 0");
        end
        send(OPI, 3'd0, F0, 32'd5, 32'd6, 5'd5, 32'd11, 1);
        wait_out(n);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_back_to_back();
        test_backpressure();
        test_rdy_stall();
        test_rst_abort();
        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
